// File: rtl/io_supply_sequencer_if.sv
// Control/status bundle between the SoC power manager and the IO supply sequencer.
interface io_supply_sequencer_if #(
  parameter int unsigned N_DOM = 3
);
  localparam int unsigned IDX_W = (N_DOM > 1) ? $clog2(N_DOM) : 1;

  logic             pwr_up_req;
  logic             pwr_dn_req;
  logic [N_DOM-1:0] pgood;
  logic             clr_fault;
  logic [N_DOM-1:0] sw_en;
  logic             iso_en;
  logic             io_ready;
  logic             busy;
  logic             fault;
  logic [IDX_W-1:0] fault_dom;

  modport master (
    output pwr_up_req, pwr_dn_req, pgood, clr_fault,
    input  sw_en, iso_en, io_ready, busy, fault, fault_dom
  );

  modport slave (
    input  pwr_up_req, pwr_dn_req, pgood, clr_fault,
    output sw_en, iso_en, io_ready, busy, fault, fault_dom
  );
endinterface

// File: rtl/io_supply_sequencer.sv
// Ordered power-up/down of the IO ring supply domains with debounced power-good,
// ramp timeouts, pad isolation control and latched supply faults.
module io_supply_sequencer #(
  parameter int unsigned N_DOM       = 3,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned DEB_CYC     = 8,
  parameter int unsigned SETTLE_CYC  = 64,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  io_supply_sequencer_if.slave bus
);
  localparam int unsigned IDX_W = (N_DOM > 1) ? $clog2(N_DOM) : 1;
  localparam int unsigned DEB_W = $clog2(DEB_CYC + 1);

  typedef enum logic [2:0] {
    S_OFF, S_RAMP_UP, S_SETTLE, S_ISO_REL, S_ON, S_ISO_SET, S_RAMP_DN, S_FAULT
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N_DOM-1:0] sw_en_q, sw_en_d;
  logic             iso_q, iso_d, ready_q, ready_d, busy_q, busy_d, fault_q, fault_d;
  logic [IDX_W-1:0] fdom_q, fdom_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [DEB_W-1:0] deb_q, deb_d;
  logic [DEB_W-1:0] bo_q [N_DOM];
  logic [DEB_W-1:0] bo_d [N_DOM];
  logic [N_DOM-1:0] pg_s1, pg_s2;

  logic             deb_match, deb_done, timeout, settle_done, step, go_fault;
  logic             bo_hit;
  logic [IDX_W-1:0] bo_dom, top_idx, idx_inc, idx_dec, fault_idx;

  assign deb_match   = (pg_s2[idx_q] == (state_q == S_RAMP_UP));
  assign deb_done    = deb_match && (deb_q >= DEB_W'(DEB_CYC - 1));
  assign timeout     = (cyc_q >= CNT_W'(TIMEOUT_CYC - 1));
  assign settle_done = (cyc_q >= CNT_W'(SETTLE_CYC));
  assign idx_inc     = idx_q + IDX_W'(1);
  assign idx_dec     = idx_q - IDX_W'(1);

  // Brown-out detect in ON; descending scan so the lowest failing domain is reported
  always_comb begin
    bo_hit = 1'b0;
    bo_dom = '0;
    for (int i = int'(N_DOM) - 1; i >= 0; i--) begin
      if (state_q == S_ON && !pg_s2[i] && bo_q[i] >= DEB_W'(DEB_CYC - 1)) begin
        bo_hit = 1'b1;
        bo_dom = IDX_W'(i);
      end
    end
  end

  // Highest enabled domain: where a (possibly aborted) ramp-down starts
  always_comb begin
    top_idx = '0;
    for (int i = 0; i < int'(N_DOM); i++) begin
      if (sw_en_q[i]) top_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sw_en_d   = sw_en_q;
    iso_d     = iso_q;
    ready_d   = ready_q;
    fault_d   = fault_q;
    fdom_d    = fdom_q;
    go_fault  = 1'b0;
    fault_idx = idx_q;

    case (state_q)
      S_OFF: begin
        if (bus.pwr_up_req && !bus.pwr_dn_req && !fault_q) begin
          state_d    = S_RAMP_UP;
          idx_d      = '0;
          sw_en_d[0] = 1'b1;
        end
      end
      S_RAMP_UP: begin
        if (timeout) begin
          go_fault = 1'b1;
        end else if (bus.pwr_dn_req) begin
          state_d = S_ISO_SET;
        end else if (deb_done) begin
          if (idx_q < IDX_W'(N_DOM - 1)) begin
            idx_d            = idx_inc;
            sw_en_d[idx_inc] = 1'b1;
          end else begin
            state_d = S_SETTLE;
          end
        end
      end
      S_SETTLE: begin
        if (bus.pwr_dn_req) begin
          state_d = S_ISO_SET;
        end else if (settle_done) begin
          state_d = S_ISO_REL;
          iso_d   = 1'b0;
        end
      end
      S_ISO_REL: begin
        state_d = S_ON;
        ready_d = 1'b1;
      end
      S_ON: begin
        if (bo_hit) begin
          go_fault  = 1'b1;
          fault_idx = bo_dom;
        end else if (bus.pwr_dn_req) begin
          state_d = S_ISO_SET;
          ready_d = 1'b0;
          iso_d   = 1'b1;
        end
      end
      S_ISO_SET: begin
        state_d          = S_RAMP_DN;
        idx_d            = top_idx;
        sw_en_d[top_idx] = 1'b0;
      end
      S_RAMP_DN: begin
        if (timeout) begin
          go_fault = 1'b1;
        end else if (deb_done) begin
          if (idx_q != '0) begin
            idx_d            = idx_dec;
            sw_en_d[idx_dec] = 1'b0;
          end else begin
            state_d = S_OFF;
          end
        end
      end
      S_FAULT: begin
        if (bus.clr_fault) begin
          state_d = S_OFF;
          fault_d = 1'b0;
        end
      end
      default: state_d = S_OFF;
    endcase

    if (go_fault) begin
      state_d = S_FAULT;
      fault_d = 1'b1;
      fdom_d  = fault_idx;
      sw_en_d = '0;
      iso_d   = 1'b1;
      ready_d = 1'b0;
    end

    busy_d = (state_d == S_RAMP_UP) || (state_d == S_SETTLE) || (state_d == S_ISO_REL) ||
             (state_d == S_ISO_SET) || (state_d == S_RAMP_DN);

    // Counters restart whenever the sequence moves to a new state or domain
    step  = (state_d != state_q) || (idx_d != idx_q);
    cyc_d = step ? '0 : ((cyc_q == '1) ? cyc_q : cyc_q + CNT_W'(1));
    if (step || !deb_match)          deb_d = '0;
    else if (deb_q >= DEB_W'(DEB_CYC)) deb_d = deb_q;
    else                             deb_d = deb_q + DEB_W'(1);
    for (int i = 0; i < int'(N_DOM); i++) begin
      if (state_q == S_ON && !pg_s2[i])
        bo_d[i] = (bo_q[i] >= DEB_W'(DEB_CYC)) ? bo_q[i] : bo_q[i] + DEB_W'(1);
      else
        bo_d[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_OFF;
      idx_q   <= '0;
      sw_en_q <= '0;
      iso_q   <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
      fdom_q  <= '0;
      cyc_q   <= '0;
      deb_q   <= '0;
      pg_s1   <= '0;
      pg_s2   <= '0;
      for (int i = 0; i < int'(N_DOM); i++) bo_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sw_en_q <= sw_en_d;
      iso_q   <= iso_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      fault_q <= fault_d;
      fdom_q  <= fdom_d;
      cyc_q   <= cyc_d;
      deb_q   <= deb_d;
      pg_s1   <= bus.pgood;
      pg_s2   <= pg_s1;
      for (int i = 0; i < int'(N_DOM); i++) bo_q[i] <= bo_d[i];
    end
  end

  assign bus.sw_en     = sw_en_q;
  assign bus.iso_en    = iso_q;
  assign bus.io_ready  = ready_q;
  assign bus.busy      = busy_q;
  assign bus.fault     = fault_q;
  assign bus.fault_dom = fdom_q;
endmodule
